// File: rtl/acc_core_p.sv
// Parametrised multi-cycle accumulator core: start/done run control, carry flag,
// PC-relative branches and a req/ack data-memory port of arbitrary latency.
module acc_core_p #(
  parameter int unsigned DW  = 8,
  parameter int unsigned RAW = 4,
  parameter int unsigned PCW = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           done,
  output logic [PCW-1:0] imem_addr,
  input  logic [RAW+4:0] imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack
);

  localparam int unsigned IW   = RAW + 5;
  localparam int unsigned NREG = 1 << RAW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SHL   = 4'h5,
    OP_SHR   = 4'h6,
    OP_LDI   = 4'h7,
    OP_MOV   = 4'h8,
    OP_BZ    = 4'h9,
    OP_BNZ   = 4'hA,
    OP_LD    = 4'hB,
    OP_ST    = 4'hC,
    OP_JMP   = 4'hD,
    OP_HALT  = 4'hE,
    OP_CARRY = 4'hF
  } op_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic           carry_q, carry_d;
  logic [DW-1:0]  r_q [NREG];
  logic [DW-1:0]  r_d [NREG];
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  op_e            op;
  logic           flag;
  logic [RAW-1:0] rs;
  logic [RAW:0]   imm;
  logic [DW-1:0]  rv;
  logic [DW:0]    sum;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] br_tgt;

  assign op     = op_e'(imem_data[IW-1:IW-4]);
  assign flag   = imem_data[RAW];
  assign rs     = imem_data[RAW-1:0];
  assign imm    = imem_data[RAW:0];
  assign rv     = r_q[rs];
  assign pc_inc = pc_q + PCW'(1);
  // imm is a signed offset; the sized cast sign-extends before the modulo-2^PCW add
  assign br_tgt = pc_q + PCW'($signed(imm));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    r_d     = r_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sum     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        pc_d = pc_inc;
        unique case (op)
          OP_ADD: begin
            sum     = {1'b0, acc_q} + {1'b0, rv} + (DW+1)'(flag & carry_q);
            acc_d   = sum[DW-1:0];
            carry_d = sum[DW];
          end
          OP_SUB: begin
            acc_d   = acc_q - rv;
            carry_d = (acc_q >= rv);
          end
          OP_AND: acc_d = acc_q & rv;
          OP_OR:  acc_d = acc_q | rv;
          OP_XOR: acc_d = acc_q ^ rv;
          OP_SHL: begin
            carry_d = acc_q[DW-1];
            acc_d   = {acc_q[DW-2:0], flag & carry_q};
          end
          OP_SHR: begin
            carry_d = acc_q[0];
            acc_d   = {flag & carry_q, acc_q[DW-1:1]};
          end
          OP_LDI: acc_d = DW'(imm);
          OP_MOV: begin
            if (flag) acc_d = rv;
            else      r_d[rs] = acc_q;
          end
          OP_BZ:  pc_d = (acc_q == '0) ? br_tgt : pc_inc;
          OP_BNZ: pc_d = (acc_q != '0) ? br_tgt : pc_inc;
          OP_LD, OP_ST: begin
            // pc holds until the ack so a stalled access never skips ahead
            pc_d    = pc_q;
            req_d   = 1'b1;
            we_d    = (op == OP_ST);
            addr_d  = rv;
            wdata_d = acc_q;
            state_d = S_WAIT;
          end
          OP_JMP: pc_d = br_tgt;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALTED;
          end
          OP_CARRY: carry_d = flag;
          default: ;
        endcase
      end
      S_WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          pc_d    = pc_inc;
          state_d = S_RUN;
          if (!we_q) acc_d = dmem_rdata;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int unsigned i = 0; i < NREG; i++) r_q[i] <= r_d[i];
    end
  end

  assign done       = (state_q == S_HALTED);
  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_acc_core_p.sv
// Bench for acc_core_p: small programs in a shared ROM, memory transactions checked
// against a queue of expected accesses; DW=8/RAW=4 and DW=16/RAW=3 instances.
module tb_acc_core_p;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                         OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_LDI = 4'h7,
                         OP_MOV = 4'h8, OP_BZ = 4'h9, OP_BNZ = 4'hA, OP_LD = 4'hB,
                         OP_ST = 4'hC, OP_JMP = 4'hD, OP_HALT = 4'hE, OP_CRY = 4'hF;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned dly;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start8 = 1'b0, start16 = 1'b0;
  logic sel = 1'b0;
  logic ack = 1'b0;
  logic [15:0] rdata = '0;

  logic [8:0]  imem_addr8, imem_addr16;
  logic [8:0]  imem_data8;
  logic [7:0]  imem_data16;
  logic        done8, done16, req8, req16, we8, we16;
  logic [7:0]  addr8, wdata8;
  logic [15:0] addr16, wdata16;
  logic        m_req, m_we, m_done;
  logic [15:0] m_addr, m_wdata;

  logic [8:0]  rom [512];
  logic [15:0] mem [256];
  txn_t        exp_q [$];
  int unsigned n_total = 0, n_bad = 0;
  int unsigned cyc = 0;
  int unsigned p = 0;

  always #5 clk = ~clk;

  acc_core_p #(.DW(8), .RAW(4), .PCW(9)) u_dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .done(done8),
    .imem_addr(imem_addr8), .imem_data(imem_data8),
    .dmem_req(req8), .dmem_we(we8), .dmem_addr(addr8), .dmem_wdata(wdata8),
    .dmem_rdata(rdata[7:0]), .dmem_ack(ack & ~sel)
  );

  acc_core_p #(.DW(16), .RAW(3), .PCW(9)) u_dut16 (
    .clk(clk), .reset(rst_n), .start(start16), .done(done16),
    .imem_addr(imem_addr16), .imem_data(imem_data16),
    .dmem_req(req16), .dmem_we(we16), .dmem_addr(addr16), .dmem_wdata(wdata16),
    .dmem_rdata(rdata), .dmem_ack(ack & sel)
  );

  assign imem_data8  = rom[imem_addr8];
  assign imem_data16 = rom[imem_addr16][7:0];
  assign m_req   = sel ? req16 : req8;
  assign m_we    = sel ? we16 : we8;
  assign m_done  = sel ? done16 : done8;
  assign m_addr  = sel ? addr16 : {8'h00, addr8};
  assign m_wdata = sel ? wdata16 : {8'h00, wdata8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] i8(input logic [3:0] op, input logic [4:0] imm);
    return {op, imm};
  endfunction

  function automatic logic [8:0] i16(input logic [3:0] op, input logic [3:0] imm);
    return {1'b0, op, imm};
  endfunction

  task automatic clr_rom(input logic s16);
    for (int i = 0; i < 512; i++) rom[i] = s16 ? i16(OP_HALT, 4'h0) : i8(OP_HALT, 5'h00);
    p = 0;
  endtask

  task automatic emit(input logic [8:0] w);
    rom[p] = w;
    p++;
  endtask

  task automatic exp_st(input logic [15:0] a, input logic [15:0] d, input int unsigned dly);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d; t.dly = dly;
    exp_q.push_back(t);
  endtask

  task automatic exp_ld(input logic [15:0] a, input logic [15:0] d, input int unsigned dly);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = d; t.dly = dly;
    exp_q.push_back(t);
  endtask

  // Memory responder: checks each access against the queue head and acks after dly cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0;
      cyc = 0;
    end else if (ack) begin
      ack = 1'b0;
      cyc = 0;
      chk("req_fall", 32'(m_req), 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (m_req) begin
      if (cyc == 0) chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("dm_we", 32'(m_we), 32'(exp_q[0].we));
        chk("dm_addr", 32'(m_addr), 32'(exp_q[0].addr));
        chk("dm_wdata", 32'(m_wdata), 32'(exp_q[0].wdata));
        cyc++;
        if (cyc == exp_q[0].dly) begin
          ack = 1'b1;
          rdata = mem[m_addr[7:0]];
        end
      end
    end else if (cyc != 0) begin
      chk("req_held", 32'(m_req), 32'd1);
      cyc = 0;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_pulse(input logic s16);
    sel = s16;
    @(posedge clk);
    #1;
    if (s16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (m_done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", 32'(m_done), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h44] = 16'h00A5;
    mem[8'hC0] = 16'hA5A5;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_req", 32'(req8), 32'd0);
    chk("rst_pc", 32'(imem_addr8), 32'd0);
    chk("rst_we", 32'(we8), 32'd0);
    chk("rst_addr", 32'(addr8), 32'd0);
    chk("rst_wdata", 32'(wdata8), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic run: done rises 5 cycles after the start edge and stays
    clr_rom(1'b0);
    emit(i8(OP_LDI, 5'h05));
    emit(i8(OP_MOV, 5'h03));
    emit(i8(OP_LDI, 5'h00));
    emit(i8(OP_MOV, 5'h13));
    start_pulse(1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("done_early", 32'(done8), 32'd0);
    @(posedge clk);
    #1;
    chk("done_at5", 32'(done8), 32'd1);
    chk("halt_pc", 32'(imem_addr8), 32'd4);
    start_pulse(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", 32'(done8), 32'd1);
    chk("halt_pc_hold", 32'(imem_addr8), 32'd4);

    // Arithmetic, carry, shifts, logic ops
    do_reset();
    clr_rom(1'b0);
    emit(i8(OP_LDI, 5'h10));
    emit(i8(OP_SHL, 5'h00));
    emit(i8(OP_MOV, 5'h01));
    emit(i8(OP_LDI, 5'h0F));
    repeat (4) emit(i8(OP_SHL, 5'h00));
    emit(i8(OP_ADD, 5'h01));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h10, 1);
    emit(i8(OP_ADD, 5'h11));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h31, 2);
    emit(i8(OP_CRY, 5'h10));
    emit(i8(OP_LDI, 5'h02));
    emit(i8(OP_SHR, 5'h10));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h81, 1);
    emit(i8(OP_LDI, 5'h00));
    emit(i8(OP_ADD, 5'h10));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h00, 1);
    emit(i8(OP_LDI, 5'h03));
    emit(i8(OP_SUB, 5'h01));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'hE3, 1);
    emit(i8(OP_SUB, 5'h00));
    emit(i8(OP_LDI, 5'h00));
    emit(i8(OP_ADD, 5'h10));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h01, 1);
    emit(i8(OP_LDI, 5'h1C));
    emit(i8(OP_XOR, 5'h01));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h3C, 1);
    emit(i8(OP_AND, 5'h01));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h20, 1);
    emit(i8(OP_LDI, 5'h03));
    emit(i8(OP_OR, 5'h01));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h23, 1);
    start_pulse(1'b0);
    wait_done(200);

    // Branches and pc wrap
    do_reset();
    clr_rom(1'b0);
    rom[0]      = i8(OP_JMP, 5'h1F);
    rom[9'h1FF] = i8(OP_JMP, 5'h03);
    rom[2]      = i8(OP_LDI, 5'h00);
    rom[3]      = i8(OP_JMP, 5'h04);
    rom[5]      = i8(OP_LDI, 5'h01);
    rom[6]      = i8(OP_CRY, 5'h00);
    rom[7]      = i8(OP_BZ, 5'h1E);
    rom[8]      = i8(OP_LDI, 5'h0A);
    rom[9]      = i8(OP_ST, 5'h00);  exp_st(16'h0, 16'h0A, 1);
    rom[10]     = i8(OP_BNZ, 5'h02);
    rom[12]     = i8(OP_LDI, 5'h00);
    rom[13]     = i8(OP_BNZ, 5'h02);
    rom[14]     = i8(OP_ST, 5'h00);  exp_st(16'h0, 16'h00, 1);
    start_pulse(1'b0);
    @(posedge clk); #1 chk("jmp_wrap_back", 32'(imem_addr8), 32'h1FF);
    @(posedge clk); #1 chk("jmp_wrap_fwd", 32'(imem_addr8), 32'h002);
    repeat (3) @(posedge clk);
    #1 chk("bz_taken", 32'(imem_addr8), 32'h005);
    repeat (3) @(posedge clk);
    #1 chk("bz_not_taken", 32'(imem_addr8), 32'h008);
    wait_done(100);

    // Load with 3-cycle ack, store with immediate ack
    do_reset();
    clr_rom(1'b0);
    emit(i8(OP_LDI, 5'h11));
    emit(i8(OP_SHL, 5'h00));
    emit(i8(OP_SHL, 5'h00));
    emit(i8(OP_MOV, 5'h02));
    emit(i8(OP_LD, 5'h02));  exp_ld(16'h44, 16'h44, 3);
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'hA5, 1);
    start_pulse(1'b0);
    wait_done(100);

    // Reset during WAIT clears everything at once
    do_reset();
    clr_rom(1'b0);
    emit(i8(OP_LDI, 5'h07));
    emit(i8(OP_MOV, 5'h01));
    emit(i8(OP_CRY, 5'h10));
    emit(i8(OP_ST, 5'h01));  exp_st(16'h7, 16'h7, 1000);
    start_pulse(1'b0);
    begin
      int unsigned n = 0;
      while (req8 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("wait_req_seen", 32'(req8), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req8), 32'd0);
    chk("mid_rst_pc", 32'(imem_addr8), 32'd0);
    chk("mid_rst_we", 32'(we8), 32'd0);
    chk("mid_rst_addr", 32'(addr8), 32'd0);
    chk("mid_rst_wdata", 32'(wdata8), 32'd0);
    exp_q.delete();
    clr_rom(1'b0);
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h00, 1);
    emit(i8(OP_MOV, 5'h11));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h00, 1);
    emit(i8(OP_ADD, 5'h10));
    emit(i8(OP_ST, 5'h00));  exp_st(16'h0, 16'h00, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_pc", 32'(imem_addr8), 32'd0);
    chk("idle_done", 32'(done8), 32'd0);
    start_pulse(1'b0);
    wait_done(100);

    // Wider data path: DW=16, RAW=3
    do_reset();
    clr_rom(1'b1);
    emit(i16(OP_LDI, 4'hC));
    emit(i16(OP_SHL, 4'h0));
    emit(i16(OP_SHL, 4'h0));
    emit(i16(OP_MOV, 4'h1));
    emit(i16(OP_LDI, 4'h0));
    emit(i16(OP_SUB, 4'h1));
    emit(i16(OP_ST, 4'h0));  exp_st(16'h0, 16'hFFD0, 1);
    emit(i16(OP_ADD, 4'h1));
    emit(i16(OP_ST, 4'h0));  exp_st(16'h0, 16'h0000, 1);
    emit(i16(OP_ADD, 4'h9));
    emit(i16(OP_ST, 4'h0));  exp_st(16'h0, 16'h0031, 1);
    emit(i16(OP_LDI, 4'hC));
    repeat (4) emit(i16(OP_SHL, 4'h0));
    emit(i16(OP_MOV, 4'h2));
    emit(i16(OP_LD, 4'h2));  exp_ld(16'hC0, 16'hC0, 3);
    emit(i16(OP_ST, 4'h0));  exp_st(16'h0, 16'hA5A5, 2);
    start_pulse(1'b1);
    wait_done(200);
    chk("dut8_idle", 32'(done8), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
